// File: rtl/blockram_bus_arbiter.sv
// Two-master sequencer for one single-port synchronous block RAM.
// Master 1: 68030-style CPU bus (SIZE/RWn, DSACKn termination).
// Master 2: DMA/loader port with a req/ack handshake.
// Every transfer runs IDLE -> ACCESS -> CAPTURE -> [WAIT] -> ACK -> IDLE.
module blockram_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  // CPU bus
  input  logic              cpu_req,
  input  logic              cpu_rwn,
  input  logic [1:0]        cpu_size,
  input  logic [31:0]       cpu_adr,
  input  logic [31:0]       cpu_dout,
  output logic [31:0]       cpu_din,
  output logic [1:0]        cpu_dsackn,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-3:0] dma_adr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_be,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  // Block RAM
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_WAIT,
    S_ACK
  } state_t;

  typedef enum logic {
    M_CPU,
    M_DMA
  } master_t;

  // Counter preload so that WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state, next_state;
  // Owner of the current transfer; after it ends it is the last master served,
  // which is what the tie-break alternates against.
  master_t     last_grant, grant_nxt;
  logic [3:0]  wait_cnt;
  logic [31:0] data_q;
  logic [31:0] term_data;
  logic [3:0]  cpu_mask;
  logic        cpu_abort;

  // Upper CPU address bits are deliberately not decoded: the RAM aliases.
  logic unused_adr_bits;
  assign unused_adr_bits = ^cpu_adr[31:ADDR_W];

  // CPU byte lanes: lanes ofs .. ofs+n-1 (lane 0 = bit 3), anything past lane 3
  // is dropped because the CPU re-runs the remainder as a new cycle.
  function automatic logic [3:0] lane_mask(input logic [1:0] ofs, input logic [1:0] size);
    logic [2:0] n;
    logic [2:0] end_excl;
    n        = (size == 2'b00) ? 3'd4 : {1'b0, size};
    end_excl = {1'b0, ofs} + n;
    return (4'hF >> ofs) & ~(4'hF >> end_excl);
  endfunction

  assign cpu_mask  = lane_mask(cpu_adr[1:0], cpu_size);
  assign cpu_abort = (last_grant == M_CPU) && !cpu_req;
  // With no wait states the data is terminated in the same edge it is captured.
  assign term_data = (state == S_CAPTURE) ? ram_rdata : data_q;

  // Next-state, arbitration and RAM strobe decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    grant_nxt  = last_grant;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = (last_grant == M_CPU) ? cpu_adr[ADDR_W-1:2] : dma_adr;
    ram_wdata  = (last_grant == M_CPU) ? cpu_dout : dma_wdata;
    case (state)
      S_IDLE: begin
        if (cpu_req && (!dma_req || last_grant == M_DMA)) begin
          grant_nxt  = M_CPU;
          next_state = S_ACCESS;
        end else if (dma_req) begin
          grant_nxt  = M_DMA;
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // The strobe is issued even if the CPU is aborting: a write in flight completes.
        ram_en = 1'b1;
        if (last_grant == M_CPU) ram_we = cpu_rwn ? 4'b0000 : cpu_mask;
        else                     ram_we = dma_we ? dma_be : 4'b0000;
        next_state = cpu_abort ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cpu_abort)             next_state = S_IDLE;
        else if (WAIT_STATES == 0) next_state = S_ACK;
        else                       next_state = S_WAIT;
      end
      S_WAIT: begin
        if (cpu_abort)            next_state = S_IDLE;
        else if (wait_cnt == 4'd0) next_state = S_ACK;
      end
      S_ACK: begin
        // DMA ack is a single pulse; the CPU holds termination until it ends the cycle.
        if (last_grant == M_DMA || !cpu_req) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State, grant owner, wait counter and read-data capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= M_DMA;
      wait_cnt   <= 4'd0;
      data_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state      <= next_state;
      last_grant <= grant_nxt;
      if (state == S_CAPTURE) begin
        wait_cnt <= WAIT_LOAD;
        data_q   <= ram_rdata;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Registered termination outputs for both masters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_dsackn <= 2'b11;
      cpu_din    <= '0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_ack <= 1'b0;
      if (next_state == S_ACK && state != S_ACK) begin
        if (last_grant == M_CPU) begin
          cpu_dsackn <= 2'b00;
          cpu_din    <= term_data;
        end else begin
          dma_ack   <= 1'b1;
          dma_rdata <= term_data;
        end
      end else if (state == S_ACK && next_state == S_IDLE && last_grant == M_CPU) begin
        cpu_dsackn <= 2'b11;
        cpu_din    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_blockram_bus_arbiter.sv
// Directed bench for blockram_bus_arbiter: one instance with no wait states,
// one with three. Each has its own RAM model; the idle instance is held in reset.
module tb_blockram_bus_arbiter;

  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic              rst0, rst1;
  logic              cpu_req, cpu_rwn;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_adr, cpu_dout;
  logic              dma_req, dma_we;
  logic [AW-3:0]     dma_adr;
  logic [31:0]       dma_wdata;
  logic [3:0]        dma_be;

  // Per-instance outputs and RAM read data
  logic [31:0]   cpu_din0, cpu_din1, dma_rdata0, dma_rdata1;
  logic [1:0]    cpu_dsackn0, cpu_dsackn1;
  logic          dma_ack0, dma_ack1, ram_en0, ram_en1;
  logic [3:0]    ram_we0, ram_we1;
  logic [AW-3:0] ram_addr0, ram_addr1;
  logic [31:0]   ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

  blockram_bus_arbiter #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0),
    .cpu_req(cpu_req), .cpu_rwn(cpu_rwn), .cpu_size(cpu_size), .cpu_adr(cpu_adr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din0), .cpu_dsackn(cpu_dsackn0),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_be(dma_be), .dma_rdata(dma_rdata0), .dma_ack(dma_ack0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  blockram_bus_arbiter #(.ADDR_W(AW), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst1),
    .cpu_req(cpu_req), .cpu_rwn(cpu_rwn), .cpu_size(cpu_size), .cpu_adr(cpu_adr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din1), .cpu_dsackn(cpu_dsackn1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_be(dma_be), .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  // Synchronous single-port RAM models, read-before-write, 1-cycle latency.
  logic [31:0] mem0 [0:(2**(AW-2))-1];
  logic [31:0] mem1 [0:(2**(AW-2))-1];

  always @(posedge clk) begin
    if (ram_en0) begin
      if (ram_we0[3]) mem0[ram_addr0][31:24] <= ram_wdata0[31:24];
      if (ram_we0[2]) mem0[ram_addr0][23:16] <= ram_wdata0[23:16];
      if (ram_we0[1]) mem0[ram_addr0][15:8]  <= ram_wdata0[15:8];
      if (ram_we0[0]) mem0[ram_addr0][7:0]   <= ram_wdata0[7:0];
      ram_rdata0 <= mem0[ram_addr0];
    end
  end

  always @(posedge clk) begin
    if (ram_en1) begin
      if (ram_we1[3]) mem1[ram_addr1][31:24] <= ram_wdata1[31:24];
      if (ram_we1[2]) mem1[ram_addr1][23:16] <= ram_wdata1[23:16];
      if (ram_we1[1]) mem1[ram_addr1][15:8]  <= ram_wdata1[15:8];
      if (ram_we1[0]) mem1[ram_addr1][7:0]   <= ram_wdata1[7:0];
      ram_rdata1 <= mem1[ram_addr1];
    end
  end

  // Observation mux: sel1 picks which instance the checks look at.
  logic          sel1;
  logic [31:0]   o_din, o_rdata, o_wdata;
  logic [1:0]    o_dsackn;
  logic          o_ack, o_en;
  logic [3:0]    o_we;
  logic [AW-3:0] o_addr;
  assign o_din    = sel1 ? cpu_din1    : cpu_din0;
  assign o_rdata  = sel1 ? dma_rdata1  : dma_rdata0;
  assign o_wdata  = sel1 ? ram_wdata1  : ram_wdata0;
  assign o_dsackn = sel1 ? cpu_dsackn1 : cpu_dsackn0;
  assign o_ack    = sel1 ? dma_ack1    : dma_ack0;
  assign o_en     = sel1 ? ram_en1     : ram_en0;
  assign o_we     = sel1 ? ram_we1     : ram_we0;
  assign o_addr   = sel1 ? ram_addr1   : ram_addr0;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dsackn"}, 32'(o_dsackn), 32'h3);
    check({tag, "_din"},    o_din,         32'h0);
    check({tag, "_ack"},    32'(o_ack),    32'h0);
    check({tag, "_rdata"},  o_rdata,       32'h0);
    check({tag, "_en"},     32'(o_en),     32'h0);
    check({tag, "_we"},     32'(o_we),     32'h0);
  endtask

  // One complete CPU cycle starting from IDLE; ends back in IDLE.
  task automatic cpu_xfer(input string tag, input logic [31:0] adr, input logic [1:0] size,
                          input logic rwn, input logic [31:0] dout, input logic [3:0] exp_we,
                          input logic [31:0] exp_din, input int ws);
    cpu_adr = adr; cpu_size = size; cpu_rwn = rwn; cpu_dout = dout; cpu_req = 1'b1;
    tick();                                            // edge 0 samples request
    check({tag, "_en"},   32'(o_en),   32'h1);
    check({tag, "_we"},   32'(o_we),   32'(exp_we));
    check({tag, "_addr"}, 32'(o_addr), 32'(adr[AW-1:2]));
    if (!rwn) check({tag, "_wdata"}, o_wdata, dout);
    repeat (1 + ws) begin
      tick();
      check({tag, "_early"}, 32'(o_dsackn), 32'h3);
    end
    tick();                                            // edge 2+ws
    check({tag, "_dsackn"}, 32'(o_dsackn), 32'h0);
    if (rwn) check({tag, "_din"}, o_din, exp_din);
    cpu_req = 1'b0;
    tick();
    check({tag, "_release"}, 32'(o_dsackn), 32'h3);
    check({tag, "_din0"},    o_din,         32'h0);
  endtask

  // One complete DMA transfer starting from IDLE; ends back in IDLE.
  task automatic dma_xfer(input string tag, input logic [AW-3:0] adr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input int ws);
    dma_adr = adr; dma_we = we; dma_wdata = wdata; dma_be = be; dma_req = 1'b1;
    tick();
    check({tag, "_en"},   32'(o_en),   32'h1);
    check({tag, "_addr"}, 32'(o_addr), 32'(adr));
    check({tag, "_we"},   32'(o_we),   we ? 32'(be) : 32'h0);
    repeat (1 + ws) begin
      tick();
      check({tag, "_early"}, 32'(o_ack), 32'h0);
    end
    tick();
    check({tag, "_ack"}, 32'(o_ack), 32'h1);
    if (!we) check({tag, "_rdata"}, o_rdata, exp_rdata);
    dma_req = 1'b0;
    tick();
    check({tag, "_pulse"}, 32'(o_ack), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sel1 = 1'b0;
    cpu_req = 1'b0; cpu_rwn = 1'b1; cpu_size = 2'b00; cpu_adr = '0; cpu_dout = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wdata = '0; dma_be = '0;

    mem0[4]  <= 32'hDEADBEEF;
    mem0[8]  <= 32'hAAAA0001; mem0[9]  <= 32'hBBBB0002;
    mem0[10] <= 32'hAAAA0003; mem0[11] <= 32'hBBBB0004; mem0[12] <= 32'hAAAA0005;
    mem0[16] <= 32'hAABBCCDD; mem0[17] <= 32'hAABBCCDD;
    mem0[18] <= 32'hAABBCCDD; mem0[19] <= 32'hAABBCCDD;
    mem0[20] <= 32'h00000000; mem0[21] <= 32'h00000000;
    mem1[4]  <= 32'h12345678; mem1[5]  <= 32'h9ABCDEF0;

    // Reset values, during and after reset.
    tick(); tick();
    check_reset_outputs("rst_hold");
    rst0 = 1'b0;
    tick();
    check_reset_outputs("rst_rel");

    // Long read; upper address bits alias onto the same word.
    cpu_xfer("rd10",   32'h0000_0010, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    cpu_xfer("alias",  32'hFFFF_0010, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hDEADBEEF, 0);

    // Sized writes and lane-exact readback.
    cpu_xfer("wr_b3",  32'h0000_0043, 2'b01, 1'b0, 32'h11223344, 4'b0001, 32'h0, 0);
    cpu_xfer("wr_w3",  32'h0000_0047, 2'b10, 1'b0, 32'h11223344, 4'b0001, 32'h0, 0);
    cpu_xfer("wr_t1",  32'h0000_0049, 2'b11, 1'b0, 32'h11223344, 4'b0111, 32'h0, 0);
    cpu_xfer("wr_l2",  32'h0000_004E, 2'b00, 1'b0, 32'h11223344, 4'b0011, 32'h0, 0);
    cpu_xfer("rb_b3",  32'h0000_0040, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hAABBCC44, 0);
    cpu_xfer("rb_w3",  32'h0000_0044, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hAABBCC44, 0);
    cpu_xfer("rb_t1",  32'h0000_0048, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hAA223344, 0);
    cpu_xfer("rb_l2",  32'h0000_004C, 2'b00, 1'b1, 32'h0, 4'b0000, 32'hAABB3344, 0);

    // DMA write with sparse byte enables, read back by the CPU.
    dma_xfer("dwr",    14'd21, 1'b1, 32'h55667788, 4'b1010, 32'h0, 0);
    cpu_xfer("rb_dwr", 32'h0000_0054, 2'b00, 1'b1, 32'h0, 4'b0000, 32'h55007700, 0);

    // CPU write aborted in CAPTURE: RAM still written, no termination, IDLE next.
    cpu_adr = 32'h0000_0050; cpu_size = 2'b00; cpu_rwn = 1'b0; cpu_dout = 32'hCAFEF00D;
    cpu_req = 1'b1;
    tick();
    check("abt_we", 32'(o_we), 32'hF);
    tick();
    cpu_req = 1'b0;
    check("abt_ds1", 32'(o_dsackn), 32'h3);
    tick();
    check("abt_ds2", 32'(o_dsackn), 32'h3);
    dma_adr = 14'd20; dma_we = 1'b0; dma_req = 1'b1;
    tick();
    check("abt_idle_en",   32'(o_en),   32'h1);
    check("abt_idle_addr", 32'(o_addr), 32'd20);
    check("abt_ds3",       32'(o_dsackn), 32'h3);
    tick();
    check("abt_ds4", 32'(o_dsackn), 32'h3);
    tick();
    check("abt_ack",   32'(o_ack), 32'h1);
    check("abt_rdata", o_rdata,    32'hCAFEF00D);
    dma_req = 1'b0;
    tick();
    check("abt_pulse", 32'(o_ack), 32'h0);

    // Both masters requesting: CPU, DMA, CPU, DMA.
    cpu_adr = 32'h0000_0020; cpu_rwn = 1'b1; cpu_size = 2'b00; cpu_req = 1'b1;
    dma_adr = 14'd9; dma_we = 1'b0; dma_req = 1'b1;
    tick();
    check("arb1_addr", 32'(o_addr), 32'd8);
    tick(); tick();
    check("arb1_ds",  32'(o_dsackn), 32'h0);
    check("arb1_din", o_din,         32'hAAAA0001);
    check("arb1_noack", 32'(o_ack),  32'h0);
    cpu_req = 1'b0;
    tick();
    check("arb1_rel", 32'(o_dsackn), 32'h3);
    cpu_adr = 32'h0000_0028; cpu_req = 1'b1;
    tick();
    check("arb2_addr", 32'(o_addr), 32'd9);
    tick(); tick();
    check("arb2_ack",   32'(o_ack),    32'h1);
    check("arb2_rdata", o_rdata,       32'hBBBB0002);
    check("arb2_cpuwait", 32'(o_dsackn), 32'h3);
    dma_adr = 14'd11;
    tick();
    check("arb2_pulse", 32'(o_ack), 32'h0);
    tick();
    check("arb3_addr", 32'(o_addr), 32'd10);
    tick(); tick();
    check("arb3_ds",  32'(o_dsackn), 32'h0);
    check("arb3_din", o_din,         32'hAAAA0003);
    cpu_req = 1'b0;
    tick();
    check("arb3_rel", 32'(o_dsackn), 32'h3);
    cpu_adr = 32'h0000_0030; cpu_req = 1'b1;
    tick();
    check("arb4_addr", 32'(o_addr), 32'd11);
    tick(); tick();
    check("arb4_ack",   32'(o_ack), 32'h1);
    check("arb4_rdata", o_rdata,    32'hBBBB0004);
    dma_req = 1'b0;
    tick();
    check("arb4_pulse", 32'(o_ack), 32'h0);
    tick();
    check("arb5_addr", 32'(o_addr), 32'd12);
    tick(); tick();
    check("arb5_din", o_din, 32'hAAAA0005);
    cpu_req = 1'b0;
    tick();
    check("arb5_rel", 32'(o_dsackn), 32'h3);

    // Switch to the three-wait-state instance.
    rst0 = 1'b1; rst1 = 1'b0; sel1 = 1'b1;
    tick(); tick();
    cpu_xfer("w3_cpu", 32'h0000_0010, 2'b00, 1'b1, 32'h0, 4'b0000, 32'h12345678, 3);
    dma_xfer("w3_dma", 14'd5, 1'b0, 32'h0, 4'b0000, 32'h9ABCDEF0, 3);

    // Reset pulsed while a DMA read sits in WAIT.
    dma_adr = 14'd5; dma_we = 1'b0; dma_req = 1'b1;
    tick();
    check("rw_en", 32'(o_en), 32'h1);
    tick(); tick(); tick();
    rst1 = 1'b1;
    #1;
    check_reset_outputs("rw_async");
    tick();
    rst1 = 1'b0; dma_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rw_noack", 32'(o_ack), 32'h0);
      check("rw_noen",  32'(o_en),  32'h0);
    end

    // First tie after reset goes to the CPU, then the DMA is served.
    dma_adr = 14'd5; dma_we = 1'b0; dma_req = 1'b1;
    cpu_xfer("rw_tie_cpu", 32'h0000_0010, 2'b00, 1'b1, 32'h0, 4'b0000, 32'h12345678, 3);
    dma_xfer("rw_tie_dma", 14'd5, 1'b0, 32'h0, 4'b0000, 32'h9ABCDEF0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/blockram_bus_arbiter.md
Name: blockram_bus_arbiter

Overview:
Arbitrates one single-port synchronous block RAM, 32-bit wide with 1-cycle read latency, between two masters. The first master is the 68030-style asynchronous CPU bus: address, SIZE, RWn, DSACKn termination. The second is a simple DMA/loader port using a req/ack handshake. The block sits between the CPU core and on-chip RAM. It replaces per-cycle ad-hoc acking with a real sequencer: byte-lane enable generation, wait states and fair arbitration.

Parameters:
ADDR_W, 16, byte-address bits decoded into RAM (RAM depth = 2**(ADDR_W-2) long words)
WAIT_STATES, 0, extra clk cycles inserted before termination (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU cycle active (derived from ~DBENn), synchronous to clk
cpu_rwn  input  1  1 = read, 0 = write
cpu_size  input  2  68030 SIZE: 01 byte, 10 word, 11 three-byte, 00 long
cpu_adr  input  32  CPU byte address
cpu_dout  input  32  CPU write data; byte at address offset k on lane k (lane 0 = [31:24])
cpu_din  output  32  read data to CPU
cpu_dsackn  output  2  termination; 2'b00 = 32-bit port ack, 2'b11 = none
dma_req  input  1  DMA request, held until dma_ack
dma_we  input  1  DMA write
dma_adr  input  ADDR_W-2  DMA long-word address
dma_wdata  input  32  DMA write data
dma_be  input  4  DMA byte enables, bit 3 = lane 0 [31:24]
dma_rdata  output  32  DMA read data, valid with dma_ack
dma_ack  output  1  one-cycle completion pulse
ram_en  output  1  RAM access strobe
ram_we  output  4  RAM byte write enables, bit 3 = [31:24]
ram_addr  output  ADDR_W-2  RAM long-word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset values: cpu_dsackn = 11, cpu_din = 0, dma_ack = 0, dma_rdata = 0, ram_en = 0, ram_we = 0. State = IDLE, last_grant = DMA, so the CPU wins the first tie.
- FSM states: IDLE -> ACCESS -> CAPTURE -> WAIT (WAIT_STATES cycles, skipped if 0) -> ACK -> IDLE.
- IDLE: sample requests.
  - A single requester is granted.
  - If both request, grant the master that was not last_grant, then update last_grant (strict alternation).
- ACCESS, exactly 1 cycle:
  - ram_en = 1.
  - ram_addr = cpu_adr[ADDR_W-1:2] or dma_adr. Upper CPU address bits are ignored, so addresses alias.
  - ram_wdata = cpu_dout or dma_wdata.
  - ram_we = 0 on reads.
- ram_we is asserted only in ACCESS.
- CPU byte mask:
  - o = cpu_adr[1:0], n = (cpu_size==00) ? 4 : cpu_size.
  - Enable lanes o .. min(o+n-1, 3). Lanes past 3 are dropped; the CPU re-runs the remainder.
- DMA mask: ram_we = dma_be on write.
- CAPTURE: latch ram_rdata into the data register.
- Termination latency: counting the IDLE edge that samples the request as edge 0, termination asserts at edge 2+WAIT_STATES.
  - CPU: cpu_dsackn = 00 and cpu_din = latched data.
  - DMA: dma_ack = 1 for one cycle, with dma_rdata.
  - Writes ack with the same timing.
- CPU ACK:
  - Hold cpu_dsackn = 00 and cpu_din while cpu_req = 1.
  - On the first edge sampling cpu_req = 0: cpu_dsackn = 11, cpu_din = 0, go to IDLE.
- The next arbitration happens no earlier than the cycle after return to IDLE, so back-to-back CPU cycles are at least 4+WAIT_STATES cycles apart.
- CPU abort: if cpu_req drops in ACCESS, CAPTURE or WAIT, a write already issued completes. Then go directly to IDLE with cpu_dsackn kept at 11.
- dma_req dropping before ack is ignored; the transfer completes and dma_ack still pulses.
- A DMA that is granted is never preempted. A pending CPU request waits, with cpu_dsackn at 11.
- rst mid-operation: all outputs return to reset values immediately and no further RAM strobe is issued.

Test Plan:
- CPU long read at 0x0000_0010, RAM word = 0xDEADBEEF, WAIT_STATES=0. Expect ram_en at edge 1, cpu_dsackn = 00 at edge 2, cpu_din = 0xDEADBEEF. cpu_req low -> cpu_dsackn = 11, cpu_din = 0 next edge.
- CPU writes, data 0x11223344:
  - Byte write at offset 3 -> ram_we = 0001.
  - Word write at offset 3 -> ram_we = 0001.
  - Three-byte write at offset 1 -> ram_we = 0111.
  - Long write at offset 2 -> ram_we = 0011.
  - Readback checks only the enabled lanes changed.
- Both requesters asserted continuously for 4 transfers. Grants alternate CPU, DMA, CPU, DMA. Each dma_ack is a single cycle with the correct dma_rdata.
- WAIT_STATES=3: CPU read ack occurs at edge 5; DMA ack at edge 5.
- CPU write with cpu_req dropped in CAPTURE. RAM is updated, cpu_dsackn never goes low, and the FSM is in IDLE 1 cycle later.
- rst pulsed during WAIT of a DMA read: no dma_ack, all outputs at reset values, and the next simultaneous request is granted to the CPU.
